// File: rtl/sparc_pipe_pkg.sv
// sparc_pipe_pkg: shared constants and state encoding for the SPARC ID/EX stage
package sparc_pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0100_0000;
  localparam int CTRL_W = 16;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_HELD  = 2'b10
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with sync reset and clear (clear wins over increment)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  // count up until all-ones, then stick
  always_ff @(posedge clk)
    if (reset || clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/id_ex_pipe_register.sv
// id_ex_pipe_register: ID/EX pipeline register with stall, flush and annul; IDEX_PERF_CNT_EN adds stall/bubble counters
module id_ex_pipe_register #(
  parameter int CTRL_W = sparc_pipe_pkg::CTRL_W
`ifdef IDEX_PERF_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              annul,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [31:0]       ex_instr,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic [21:0]       ex_imm22,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef IDEX_PERF_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);
  import sparc_pipe_pkg::*;
  logic              r_valid;
  logic [31:0]       r_instr;
  logic [31:0]       r_pc;
  logic [31:0]       r_rs1;
  logic [31:0]       r_rs2;
  logic [CTRL_W-1:0] r_ctrl;
  state_t            r_state;
  logic              w_live;
  logic              w_occupied;
  assign w_live     = id_valid & ~annul;
  assign w_occupied = (r_state == ST_FULL) || (r_state == ST_HELD);
  // data registers: reset/flush load a bubble, stall holds, otherwise capture ID
  always_ff @(posedge clk)
    if (reset || flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (!stall) begin
      r_valid <= w_live;
      r_instr <= w_live ? id_instr : NOP_INSTR;
      r_ctrl  <= w_live ? id_ctrl : '0;
      r_pc    <= id_pc;
      r_rs1   <= id_rs1_data;
      r_rs2   <= id_rs2_data;
    end
  // occupancy tracking; the unused encoding falls back to EMPTY
  always_ff @(posedge clk)
    r_state <= (reset || flush) ? ST_EMPTY :
               stall            ? (w_occupied ? ST_HELD : ST_EMPTY) :
               w_live           ? ST_FULL : ST_EMPTY;
  assign ex_valid    = r_valid;
  assign ex_instr    = r_instr;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1;
  assign ex_rs2_data = r_rs2;
  assign ex_ctrl     = r_ctrl;
  assign ex_imm22    = r_instr[21:0];
  assign ex_rd       = r_instr[29:25];
`ifdef IDEX_PERF_CNT_EN
  logic w_stall_inc;
  logic w_bubble_inc;
  assign w_stall_inc  = stall & w_occupied;
  assign w_bubble_inc = flush | (~stall & id_valid & annul);
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(w_stall_inc), .count(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(w_bubble_inc), .count(bubble_cnt)
  );
`endif
endmodule

// File: tb/tb_id_ex_pipe_register.sv
// tb_id_ex_pipe_register: directed checks of load, stall, flush, annul and reset; counters under IDEX_PERF_CNT_EN
module tb_id_ex_pipe_register;
  logic        clk = 1'b0;
  logic        reset, stall, flush, annul, id_valid;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data;
  logic [15:0] id_ctrl;
  logic        ex_valid;
  logic [31:0] ex_instr, ex_pc, ex_rs1_data, ex_rs2_data;
  logic [21:0] ex_imm22;
  logic [4:0]  ex_rd;
  logic [15:0] ex_ctrl;
  int          n_vec = 0;
  int          n_err = 0;
  localparam logic [31:0] NOP = 32'h0100_0000;
  always #5 clk = ~clk;
`ifdef IDEX_PERF_CNT_EN
  logic       cnt_clr;
  logic [3:0] stall_cnt, bubble_cnt;
  id_ex_pipe_register #(.CTRL_W(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .annul(annul),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm22(ex_imm22),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );
`else
  id_ex_pipe_register #(.CTRL_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .annul(annul),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm22(ex_imm22),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
  );
`endif
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] c);
    id_valid = v; id_instr = ins; id_pc = pc; id_rs1_data = a; id_rs2_data = b; id_ctrl = c;
  endtask
  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; annul = 1'b0;
`ifdef IDEX_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    drive(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'h5555_5555, 32'hAAAA_AAAA, 16'hFFFF);
    step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_instr", ex_instr, NOP);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_rs1", ex_rs1_data, 0);
    chk("rst_rs2", ex_rs2_data, 0);
    chk("rst_state", dut.r_state, 0);
    reset = 1'b0;
    drive(1'b1, 32'h8600_6005, 32'h0000_1000, 32'h0000_0011, 32'hDEAD_BEEF, 16'h00A5);
    step();
    chk("ld_instr", ex_instr, 32'h8600_6005);
    chk("ld_rs2", ex_rs2_data, 32'hDEAD_BEEF);
    chk("ld_rs1", ex_rs1_data, 32'h11);
    chk("ld_pc", ex_pc, 32'h1000);
    chk("ld_rd", ex_rd, 3);
    chk("ld_imm22", ex_imm22, 22'h006005);
    chk("ld_valid", ex_valid, 1);
    chk("ld_ctrl", ex_ctrl, 16'h00A5);
    chk("ld_state", dut.r_state, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8400_4002 + i, 32'h2000 + i, 32'h22, 32'h33 + i, 16'h0F0F);
      annul = i[0];
      step();
      chk("stl_instr", ex_instr, 32'h8600_6005);
      chk("stl_rs2", ex_rs2_data, 32'hDEAD_BEEF);
      chk("stl_valid", ex_valid, 1);
      chk("stl_ctrl", ex_ctrl, 16'h00A5);
      chk("stl_state", dut.r_state, 2);
    end
    stall = 1'b0; annul = 1'b0;
    drive(1'b1, 32'h8400_4002, 32'h0000_2000, 32'h22, 32'h44, 16'h0F0F);
    step();
    chk("rel_instr", ex_instr, 32'h8400_4002);
    chk("rel_rd", ex_rd, 2);
    chk("rel_rs2", ex_rs2_data, 32'h44);
    chk("rel_ctrl", ex_ctrl, 16'h0F0F);
    chk("rel_state", dut.r_state, 1);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("fl_valid", ex_valid, 0);
    chk("fl_instr", ex_instr, NOP);
    chk("fl_ctrl", ex_ctrl, 0);
    chk("fl_rs2", ex_rs2_data, 0);
    chk("fl_pc", ex_pc, 0);
    chk("fl_state", dut.r_state, 0);
`ifdef IDEX_PERF_CNT_EN
    chk("cnt_stall4", stall_cnt, 4);
    chk("cnt_bub1", bubble_cnt, 1);
`endif
    flush = 1'b0;
    step();
    chk("stl_empty_state", dut.r_state, 0);
    chk("stl_empty_valid", ex_valid, 0);
    stall = 1'b0; annul = 1'b1;
    drive(1'b1, 32'h8600_6005, 32'h0000_3000, 32'h1, 32'h2, 16'h1234);
    step();
    chk("an_valid", ex_valid, 0);
    chk("an_ctrl", ex_ctrl, 0);
    chk("an_instr", ex_instr, NOP);
    chk("an_pc", ex_pc, 32'h3000);
    chk("an_state", dut.r_state, 0);
`ifdef IDEX_PERF_CNT_EN
    chk("cnt_bub2", bubble_cnt, 2);
`endif
    annul = 1'b0;
    drive(1'b0, 32'h8600_6005, 32'h0000_3004, 32'h1, 32'h2, 16'h1234);
    step();
    chk("inv_valid", ex_valid, 0);
    chk("inv_ctrl", ex_ctrl, 0);
    chk("inv_instr", ex_instr, NOP);
    drive(1'b1, 32'h8600_6005, 32'h0000_4000, 32'h1, 32'h2, 16'h1234);
    step();
    chk("pre_held_state", dut.r_state, 1);
    stall = 1'b1;
    step();
    chk("held_state", dut.r_state, 2);
    reset = 1'b1;
    step();
    chk("rh_valid", ex_valid, 0);
    chk("rh_instr", ex_instr, NOP);
    chk("rh_ctrl", ex_ctrl, 0);
    chk("rh_state", dut.r_state, 0);
`ifdef IDEX_PERF_CNT_EN
    chk("rh_cnt", stall_cnt, 0);
    reset = 1'b0; stall = 1'b0;
    step();
    stall = 1'b1;
    repeat (20) step();
    chk("sat_cnt", stall_cnt, 4'hF);
    cnt_clr = 1'b1;
    step();
    chk("clr_cnt", stall_cnt, 0);
    chk("clr_bub", bubble_cnt, 0);
    cnt_clr = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
